// File: rtl/chain_readback_checker.sv
// Configuration chain readback checker: shifts the FPGA config chain and compares
// each tail bit against a golden serial stream, reporting pass/fail and first error.
module chain_readback_checker #(
  parameter int CHAIN_LENGTH = 6140,
  parameter int IDX_W        = $clog2(CHAIN_LENGTH) + 1,
  parameter int ERR_W        = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic             i_exp_bit,
  input  logic             i_exp_valid,
  input  logic             i_chain_tail,
  output logic             o_shift_en,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_pass,
  output logic [ERR_W-1:0] o_err_count,
  output logic [IDX_W-1:0] o_first_err_idx,
  output logic             o_first_err_valid
);

  // state     | meaning
  // S_IDLE    | waiting for start after reset
  // S_COMPARE | one chain shift and compare per exp_valid cycle
  // S_DONE    | status held until next start
  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COMPARE = 2'd1,
    S_DONE    = 2'd2
  } state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CHAIN_LENGTH - 1);

  state_t             r_state;
  state_t             w_next_state;
  logic [IDX_W-1:0]   r_idx;
  logic [ERR_W-1:0]   r_err_count;
  logic [IDX_W-1:0]   r_first_err_idx;
  logic               r_first_err_valid;
  logic               r_done;
  logic               r_pass;
  logic               w_shift_en;
  logic               w_start_run;
  logic               w_cmp;
  logic               w_mismatch;
  logic               w_last;

  assign w_start_run = (r_state != S_COMPARE) && i_start;
  assign w_cmp       = (r_state == S_COMPARE) && i_exp_valid;
  assign w_mismatch  = w_cmp && (i_exp_bit != i_chain_tail);
  assign w_last      = (r_idx == LAST_IDX);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    w_shift_en   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_start) w_next_state = S_COMPARE;
      end
      S_COMPARE: begin
        w_shift_en = i_exp_valid;
        if (i_exp_valid && w_last) w_next_state = S_DONE;
      end
      S_DONE: begin
        if (i_start) w_next_state = S_COMPARE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_idx             <= '0;
      r_err_count       <= '0;
      r_first_err_idx   <= '0;
      r_first_err_valid <= 1'b0;
      r_done            <= 1'b0;
      r_pass            <= 1'b0;
    end else if (w_start_run) begin
      r_idx             <= '0;
      r_err_count       <= '0;
      r_first_err_idx   <= '0;
      r_first_err_valid <= 1'b0;
      r_done            <= 1'b0;
      r_pass            <= 1'b0;
    end else if (w_cmp) begin
      // index parks on the last position so it never runs past the chain
      if (!w_last) r_idx <= r_idx + 1'b1;
      if (w_mismatch && (r_err_count != '1)) r_err_count <= r_err_count + 1'b1;
      if (w_mismatch && !r_first_err_valid) begin
        r_first_err_idx   <= r_idx;
        r_first_err_valid <= 1'b1;
      end
      if (w_last) begin
        r_done <= 1'b1;
        r_pass <= (r_err_count == '0) && !w_mismatch;
      end
    end
  end

  assign o_shift_en        = w_shift_en;
  assign o_busy            = (r_state == S_COMPARE);
  assign o_done            = r_done;
  assign o_pass            = r_pass;
  assign o_err_count       = r_err_count;
  assign o_first_err_idx   = r_first_err_idx;
  assign o_first_err_valid = r_first_err_valid;

endmodule

// File: tb/tb_chain_readback_checker.sv
// Scoreboard bench for chain_readback_checker: two instances (ERR_W=16 and ERR_W=2)
// share stimulus; expected run results are queued and checked when done rises.
module tb_chain_readback_checker;

  localparam int CL    = 8;
  localparam int IDX_W = $clog2(CL) + 1;

  typedef struct {
    int errs;
    int errs_sat2;
    int first_idx;
    int first_valid;
    int pass;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0, exp_bit = 1'b0, exp_valid = 1'b0, chain_tail = 1'b0;

  logic             sh_a, busy_a, done_a, pass_a, fev_a;
  logic [15:0]      err_a;
  logic [IDX_W-1:0] fei_a;
  logic             sh_b, busy_b, done_b, pass_b, fev_b;
  logic [1:0]       err_b;
  logic [IDX_W-1:0] fei_b;

  int n_cmp = 0;
  int n_fail = 0;
  exp_t sb_q[$];

  always #5 clk = ~clk;

  chain_readback_checker #(.CHAIN_LENGTH(CL), .ERR_W(16)) dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_exp_bit(exp_bit),
    .i_exp_valid(exp_valid), .i_chain_tail(chain_tail), .o_shift_en(sh_a),
    .o_busy(busy_a), .o_done(done_a), .o_pass(pass_a), .o_err_count(err_a),
    .o_first_err_idx(fei_a), .o_first_err_valid(fev_a));

  chain_readback_checker #(.CHAIN_LENGTH(CL), .ERR_W(2)) dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_exp_bit(exp_bit),
    .i_exp_valid(exp_valid), .i_chain_tail(chain_tail), .o_shift_en(sh_b),
    .o_busy(busy_b), .o_done(done_b), .o_pass(pass_b), .o_err_count(err_b),
    .o_first_err_idx(fei_b), .o_first_err_valid(fev_b));

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: mismatches are just the popcount of exp XOR tail over the chain.
  function automatic exp_t model(input logic [CL-1:0] e, input logic [CL-1:0] t);
    exp_t r;
    logic [CL-1:0] d;
    d = e ^ t;
    r.errs = $countones(d);
    r.errs_sat2 = (r.errs > 3) ? 3 : r.errs;
    r.first_idx = 0;
    for (int i = CL - 1; i >= 0; i--) if (d[i]) r.first_idx = i;
    r.first_valid = (r.errs > 0) ? 1 : 0;
    r.pass = (r.errs == 0) ? 1 : 0;
    return r;
  endfunction

  // Monitor: compare full status whenever dut_a reports a newly completed run.
  logic prev_done = 1'b0;
  int   shift_cnt = 0;
  always @(negedge clk) begin
    if (sh_a) shift_cnt++;
    if (done_a && !prev_done) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("err_a", int'(err_a), e.errs);
        chk("err_b_sat", int'(err_b), e.errs_sat2);
        chk("fev_a", int'(fev_a), e.first_valid);
        chk("fev_b", int'(fev_b), e.first_valid);
        if (e.first_valid != 0) begin
          chk("fei_a", int'(fei_a), e.first_idx);
          chk("fei_b", int'(fei_b), e.first_idx);
        end
        chk("pass_a", int'(pass_a), e.pass);
        chk("pass_b", int'(pass_b), e.pass);
        chk("busy_at_done", int'(busy_a), 0);
        chk("shift_count", shift_cnt, CL);
      end
    end
    prev_done <= done_a;
  end

  // stall: 0 none, 1 pattern 1,0,0 repeating, 2 random. mid_start: random start in COMPARE.
  task automatic run(input logic [CL-1:0] e, input logic [CL-1:0] t,
                     input int stall, input bit mid_start);
    exp_t ex;
    int n = 0;
    int c = 0;
    ex = model(e, t);
    sb_q.push_back(ex);
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    shift_cnt = 0;
    while (n < CL) begin
      if (c > 200) begin
        chk("run_cycle_budget", c, 200);
        break;
      end
      case (stall)
        0:       exp_valid = 1'b1;
        1:       exp_valid = ((c % 3) == 0);
        default: exp_valid = 1'($urandom_range(0, 1));
      endcase
      exp_bit    = e[n];
      chain_tail = t[n];
      start      = mid_start ? 1'($urandom_range(0, 1)) : 1'b0;
      @(negedge clk);
      if (sh_a != exp_valid || sh_b != exp_valid) chk("shift_en_mirror", int'(sh_a), int'(exp_valid));
      if (busy_a !== 1'b1 || done_a !== 1'b0) chk("busy_in_run", int'(busy_a), 1);
      @(posedge clk); #1;
      if (exp_valid) n++;
      c++;
    end
    start = 1'b0;
    exp_valid = 1'b0;
    exp_bit = $urandom_range(0, 1);
    chain_tail = ~exp_bit;
    @(negedge clk);
    chk("done_latency", int'(done_a), 1);
    chk("shift_en_done", int'(sh_a), 0);
    // extra exp_valid pulses (all mismatching) in DONE must change nothing
    exp_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1 exp_valid = 1'b0;
    @(negedge clk);
    chk("done_hold_err", int'(err_a), ex.errs);
    chk("done_hold_done", int'(done_a), 1);
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, "_a"}, int'({sh_a, busy_a, done_a, pass_a, fev_a}) + int'(err_a) + int'(fei_a), 0);
    chk({name, "_b"}, int'({sh_b, busy_b, done_b, pass_b, fev_b}) + int'(err_b) + int'(fei_b), 0);
  endtask

  logic [CL-1:0] gold;
  logic [CL-1:0] rv;

  initial begin
    gold = 8'b1011_0010;
    #23;
    chk_all_zero("reset_state");
    rst_n = 1'b1;
    @(negedge clk);
    chk_all_zero("idle_state");

    run(gold, gold, 0, 1'b0);
    run(gold, gold ^ 8'b0100_1000, 0, 1'b0);
    run(gold, gold ^ 8'b0100_1000, 1, 1'b0);
    run(gold, ~gold, 0, 1'b0);

    // reset after 4 compare cycles aborts the run with no status left behind
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    exp_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      exp_bit = gold[i];
      chain_tail = ~gold[i];
      @(posedge clk); #1;
    end
    #2 rst_n = 1'b0;
    #1 exp_valid = 1'b0;
    chk_all_zero("async_reset");
    @(posedge clk); #2 rst_n = 1'b1;
    run(gold, gold, 0, 1'b0);

    run(gold, gold ^ 8'b0000_0110, 0, 1'b0);
    run(gold, gold, 2, 1'b1);

    for (int k = 0; k < 6; k++) begin
      rv = 8'($urandom);
      run(rv, rv ^ 8'($urandom), 2, 1'b1);
    end

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", sb_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/chain_readback_checker.md
Name: chain_readback_checker

Overview:
- Downstream of the bitstream loader on the testboard.
- Clocks the configuration chain of the FPGA under test and samples the serial chain tail.
- Compares each tail bit against a golden serial stream supplied by an upstream expected-bit source (same format as the loader's chain_head).
- Reports done, pass/fail, mismatch count and index of the first mismatching bit, so software can confirm the loaded bitstream landed intact.

Parameters:
CHAIN_LENGTH, 6140, number of bits compared per run (>=2)
IDX_W, $clog2(CHAIN_LENGTH)+1, width of bit index / first-error index
ERR_W, 16, width of mismatch counter (saturating)

Ports:
clk  input  1  system clock; all logic on rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  level/pulse; begins a run when sampled high in IDLE or DONE
exp_bit  input  1  golden bit for current chain position
exp_valid  input  1  exp_bit valid this cycle (upstream may stall)
chain_tail  input  1  serial output of DUT configuration chain, synchronous to clk
shift_en  output  1  chain clock enable to DUT; one chain shift per cycle high
busy  output  1  high in COMPARE
done  output  1  run complete; held until next start or reset
pass  output  1  done && err_count==0
err_count  output  ERR_W  number of mismatches in current/last run
first_err_idx  output  IDX_W  bit index of first mismatch
first_err_valid  output  1  first_err_idx holds a captured value

Behaviour:
- Reset (async, rst_n low): state=IDLE; shift_en, busy, done, pass, first_err_valid = 0; err_count, first_err_idx, internal bit index = 0. Reset mid-run aborts immediately; no partial status is preserved.
- States: IDLE, COMPARE, DONE.
- IDLE -> COMPARE when start=1. On this edge, clear index, err_count, first_err_idx, first_err_valid and done.
- DONE -> COMPARE when start=1, with the same clears as IDLE -> COMPARE.
- start is ignored in COMPARE.
- COMPARE:
  - shift_en = exp_valid, combinational in this state only; 0 in all other states.
  - Compare cycle = cycle with exp_valid=1. chain_tail and exp_bit are sampled on that rising edge, and index increments by 1.
  - exp_valid=0: stall; index, counters and state hold.
  - Mismatch (exp_bit != chain_tail) on a compare cycle: err_count increments, saturating at 2^ERR_W-1 with no wrap.
  - If first_err_valid=0 on a mismatch, capture first_err_idx = current index (pre-increment) and set first_err_valid.
  - Compare cycle at index == CHAIN_LENGTH-1: that bit is checked, then the next state is DONE. done=1 and busy=0 from the following cycle.
- Exactly CHAIN_LENGTH compare cycles per run; index never exceeds CHAIN_LENGTH-1.
- DONE: outputs held stable; shift_en=0; extra exp_valid pulses are ignored.
- pass is registered: it is 1 only in DONE with err_count==0, and 0 in all other states.
- Latency: status is valid 1 cycle after the final compare cycle.
- busy = (state==COMPARE).

Test Plan:
- CHAIN_LENGTH=8, exp stream 8'b1011_0010 LSB-first, chain_tail identical, exp_valid held high -> shift_en high exactly 8 cycles; done=1 on the 9th cycle after start; pass=1; err_count=0; first_err_valid=0.
- Same run with chain_tail inverted at indices 3 and 6 -> err_count=2, first_err_idx=3, first_err_valid=1, pass=0.
- exp_valid toggled 1,0,0,1,... (stalls) -> shift_en mirrors exp_valid; done only after 8 valid cycles; results identical to the no-stall run.
- ERR_W=2, all 8 bits mismatched -> err_count saturates at 3; first_err_idx=0; pass=0.
- rst_n pulsed low after 4 compare cycles -> all outputs 0 asynchronously. A new start then yields a full 8-bit run with clean counters.
- After DONE with errors, start pulsed; extra start pulses during COMPARE -> counters cleared on restart; mid-run starts have no effect; second clean run gives pass=1.
